// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with NRD combinational read ports, two write-back
// ports and a per-register busy scoreboard for operand hazard tracking.
// Register 0 is hard-wired to zero and is never busy.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write-back
// data and busy-clear onto the read ports.
module reg_file_sb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM        = 32,  // must equal 2**ADDR_WIDTH
   parameter int NRD        = 2    // 1..4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NRD*ADDR_WIDTH-1:0]  raddr,
   output logic [NRD*DATA_WIDTH-1:0]  rdata,
   output logic [NRD-1:0]             rbusy,
   input  logic                       wen0,
   input  logic [ADDR_WIDTH-1:0]      waddr0,
   input  logic [DATA_WIDTH-1:0]      wdata0,
   input  logic                       wen1,
   input  logic [ADDR_WIDTH-1:0]      waddr1,
   input  logic [DATA_WIDTH-1:0]      wdata1,
   input  logic                       issue_valid,
   input  logic [ADDR_WIDTH-1:0]      issue_addr,
   output logic                       issue_ready,
   input  logic                       flush
);

   logic [DATA_WIDTH-1:0] regs [NUM];
   logic [NUM-1:0]        busy;
   logic [NUM-1:0]        wb_hit;     // registers targeted by a write-back this cycle
   logic [NUM-1:0]        issue_hit;  // register marked pending by an accepted issue
   logic                  issue_fire;

   // Hold off a second producer of a register until the older write retires.
   always_comb begin
      issue_ready = !busy[issue_addr] || (issue_addr == '0) || flush;
   end

   assign issue_fire = issue_valid && issue_ready && (issue_addr != '0);

   // Decode write-back and issue targets into one-hot register vectors.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      wb_hit    = '0;
      issue_hit = '0;
      if (wen0)       wb_hit[waddr0]        = 1'b1;
      if (wen1)       wb_hit[waddr1]        = 1'b1;
      if (issue_fire) issue_hit[issue_addr] = 1'b1;
      wb_hit[0] = 1'b0;
   end

   // Data array: port 1 wins a same-index conflict; x0 is never written.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         // NOTE: the array is reset because the core relies on zeroed registers, which rules out a RAM macro.
         for (int r = 0; r < NUM; r++) regs[r] <= '0;
      end else begin
         for (int r = 1; r < NUM; r++) begin
            if (wen1 && waddr1 == ADDR_WIDTH'(r))      regs[r] <= wdata1;
            else if (wen0 && waddr0 == ADDR_WIDTH'(r)) regs[r] <= wdata0;
         end
      end
   end

   // Scoreboard: flush clears all, an accepted issue (younger producer) beats a write-back clear.
   always_ff @(posedge clk) begin
      if (rst)        busy <= '0;
      else if (flush) busy <= '0;
      else            busy <= (busy & ~wb_hit) | issue_hit;
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] data;
      logic                  bsy;

      assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];

      // Combinational read port with optional same-cycle forwarding.
      always_comb begin
         data = regs[ra];
         bsy  = busy[ra];
`ifdef REG_FILE_BYPASS_EN
         if (wen1 && waddr1 == ra)      data = wdata1;
         else if (wen0 && waddr0 == ra) data = wdata0;
         if (wb_hit[ra] && !issue_hit[ra]) bsy = 1'b0;
`endif
         if (ra == '0) begin
            data = '0;
            bsy  = 1'b0;
         end
      end

      assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = data;
      assign rbusy[k]                          = bsy;
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed spec scenarios followed by random traffic, all
// outputs compared every cycle against an array-based reference model.
// Honours REG_FILE_BYPASS_EN when defined for the build.
module tb_reg_file_sb;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NUM = 32;
   localparam int NRD = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NRD*AW-1:0] raddr;
   logic [NRD*DW-1:0] rdata;
   logic [NRD-1:0]    rbusy;
   logic              wen0, wen1;
   logic [AW-1:0]     waddr0, waddr1;
   logic [DW-1:0]     wdata0, wdata1;
   logic              issue_valid;
   logic [AW-1:0]     issue_addr;
   logic              issue_ready;
   logic              flush;

   int errors = 0;
   int checks = 0;

   // Reference model state: plain arrays updated from the rules.
   logic [DW-1:0] m_regs [NUM];
   bit            m_busy [NUM];

   reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM(NUM), .NRD(NRD)) dut (
      .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
      .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
      .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
      .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ready();
      return !m_busy[issue_addr] || issue_addr == 0 || flush;
   endfunction

   function automatic logic [DW-1:0] m_rdata(input logic [AW-1:0] a);
      if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
      if (wen1 && waddr1 == a) return wdata1;
      if (wen0 && waddr0 == a) return wdata0;
`endif
      return m_regs[a];
   endfunction

   function automatic bit m_rbusy(input logic [AW-1:0] a);
      if (a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
      if (((wen0 && waddr0 == a) || (wen1 && waddr1 == a)) &&
          !(issue_valid && m_ready() && issue_addr == a))
         return 1'b0;
`endif
      return m_busy[a];
   endfunction

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_update();
      bit accept;
      accept = issue_valid && m_ready();
      if (rst) begin
         for (int i = 0; i < NUM; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (wen0 && waddr0 != 0) m_regs[waddr0] = wdata0;
         if (wen1 && waddr1 != 0) m_regs[waddr1] = wdata1;
         if (flush) begin
            for (int i = 0; i < NUM; i++) m_busy[i] = 1'b0;
         end else begin
            if (wen0) m_busy[waddr0] = 1'b0;
            if (wen1) m_busy[waddr1] = 1'b0;
            if (accept && issue_addr != 0) m_busy[issue_addr] = 1'b1;
         end
      end
   endtask

   // Wait for the sampling point and compare every output with the model.
   task automatic step();
      @(negedge clk);
      for (int k = 0; k < NRD; k++) begin
         check($sformatf("rdata%0d", k), rdata[k*DW +: DW], m_rdata(raddr[k*AW +: AW]));
         check($sformatf("rbusy%0d", k), DW'(rbusy[k]), DW'(m_rbusy(raddr[k*AW +: AW])));
      end
      check("issue_ready", DW'(issue_ready), DW'(m_ready()));
   endtask

   task automatic edge_clk();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      wen0 = 0; wen1 = 0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
      issue_valid = 0; issue_addr = '0; flush = 0;
   endtask

   task automatic set_ra(input int k, input logic [AW-1:0] a);
      raddr[k*AW +: AW] = a;
   endtask

   task automatic check_all_clear(input string tag);
      for (int i = 0; i < NUM; i++) begin
         set_ra(0, AW'(i));
         set_ra(1, AW'(NUM - 1 - i));
         step();
         check({tag, "_rdata0"}, rdata[0 +: DW], '0);
         check({tag, "_rbusy"},  DW'(rbusy), '0);
         check({tag, "_ready"},  DW'(issue_ready), 1);
         edge_clk();
      end
   endtask

   initial begin
      for (int i = 0; i < NUM; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      idle();
      raddr = '0;

      // 1. Reset two cycles, then every index reads as cleared.
      rst = 1;
      edge_clk();
      edge_clk();
      rst = 0;
      check_all_clear("reset");

      // 2. Write x5 while reading it in the same cycle.
      wen0 = 1; waddr0 = 5; wdata0 = 32'hDEAD_BEEF; set_ra(0, 5);
      step();
`ifdef REG_FILE_BYPASS_EN
      check("wr5_same", rdata[0 +: DW], 32'hDEAD_BEEF);
`else
      check("wr5_same", rdata[0 +: DW], 32'h0);
`endif
      edge_clk();
      idle();
      step();
      check("wr5_next", rdata[0 +: DW], 32'hDEAD_BEEF);
      edge_clk();

      // 3. WAW hold-off on x7, released by a port-1 write-back.
      issue_valid = 1; issue_addr = 7; set_ra(0, 7);
      step();
      check("iss7_first", DW'(issue_ready), 1);
      edge_clk();
      step();
      check("iss7_blocked", DW'(issue_ready), 0);
      check("iss7_busy", DW'(rbusy[0]), 1);
      edge_clk();
      idle(); issue_addr = 7;
      wen1 = 1; waddr1 = 7; wdata1 = 32'h0000_0777;
      step();
      edge_clk();
      wen1 = 0;
      step();
      check("wb7_ready", DW'(issue_ready), 1);
      check("wb7_busy", DW'(rbusy[0]), 0);
      check("wb7_data", rdata[0 +: DW], 32'h0000_0777);
      edge_clk();

      // 4. Issue and write-back to x3 in one cycle: issue wins busy, data lands.
      idle();
      issue_valid = 1; issue_addr = 3; wen0 = 1; waddr0 = 3; wdata0 = 32'h1234;
      step();
      edge_clk();
      idle(); set_ra(0, 3);
      step();
      check("x3_busy", DW'(rbusy[0]), 1);
      check("x3_data", rdata[0 +: DW], 32'h1234);
      edge_clk();

      // 5. Dual write to x9 (port 1 wins) and a dropped write to x0.
      wen0 = 1; waddr0 = 9; wdata0 = 32'h1;
      wen1 = 1; waddr1 = 9; wdata1 = 32'h2;
      step();
      edge_clk();
      idle(); set_ra(0, 9); set_ra(1, 9);
      step();
      check("x9_p0", rdata[0 +: DW], 32'h2);
      check("x9_p1", rdata[DW +: DW], 32'h2);
      edge_clk();
      wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF; set_ra(0, 0);
      step();
      check("x0_same", rdata[0 +: DW], 32'h0);
      edge_clk();
      idle();
      step();
      check("x0_next", rdata[0 +: DW], 32'h0);
      edge_clk();

      // 6. Busy x1, x2 (x3 still busy), flush with a concurrent issue, then reset.
      issue_valid = 1; issue_addr = 1;
      step(); edge_clk();
      issue_addr = 2;
      step(); edge_clk();
      idle(); set_ra(0, 1); set_ra(1, 2);
      step();
      check("pre_flush_busy", DW'(rbusy), 2'b11);
      edge_clk();
      flush = 1; issue_valid = 1; issue_addr = 3;
      step();
      check("flush_ready", DW'(issue_ready), 1);
      edge_clk();
      idle();
      step();
      check("post_flush_12", DW'(rbusy), 2'b00);
      edge_clk();
      set_ra(0, 3);
      step();
      check("post_flush_3", DW'(rbusy[0]), 0);
      edge_clk();
      issue_valid = 1; issue_addr = 4; wen0 = 1; waddr0 = 10; wdata0 = 32'hAA;
      step(); edge_clk();
      idle(); rst = 1; wen1 = 1; waddr1 = 11; wdata1 = 32'h55; issue_valid = 1; issue_addr = 6;
      step(); edge_clk();
      idle(); rst = 0;
      check_all_clear("midrst");

      // Random traffic on a narrowed index range to provoke conflicts.
      for (int n = 0; n < 2000; n++) begin
         rst         = ($urandom_range(0, 63) == 0);
         flush       = ($urandom_range(0, 15) == 0);
         wen0        = $urandom_range(0, 1);
         wen1        = $urandom_range(0, 1);
         waddr0      = AW'($urandom_range(0, 11));
         waddr1      = AW'($urandom_range(0, 11));
         wdata0      = $urandom;
         wdata1      = $urandom;
         issue_valid = $urandom_range(0, 1);
         issue_addr  = AW'($urandom_range(0, 11));
         set_ra(0, AW'($urandom_range(0, 11)));
         set_ra(1, AW'($urandom_range(0, 11)));
         step();
         edge_clk();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
